// File: rtl/global_pkg.sv
// Project-wide boolean constants shared by all blocks.
package global_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/uart_pkg.sv
// Shared UART types: receiver FSM encoding and frame geometry.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } UART_RX_STATE_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to the idle-high level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop; mid-bit sampling
// with a one-cycle valid strobe and sticky error flags per frame.
module uart_rx
    import uart_pkg::*;
    import global_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    UART_RX_STATE_e    state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_bit_q, parity_bit_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              rx_valid_q, rx_valid_d;
    logic              parity_error_q, parity_error_d;
    logic              frame_error_q, frame_error_d;
    logic              tick_last;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign tick_last = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            tick_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            parity_bit_q   <= 1'b0;
            data_out_q     <= '0;
            rx_valid_q     <= FALSE;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            parity_bit_q   <= parity_bit_d;
            data_out_q     <= data_out_d;
            rx_valid_q     <= rx_valid_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rx_s) state_d = START;
            // A line that is high again at mid start bit was only a glitch.
            START:     if (tick_cnt_q == TICK_MID) state_d = rx_s ? IDLE : DATA;
            DATA:      if (tick_last && bit_cnt_q == BIT_LAST) state_d = PARITY;
            PARITY:    if (tick_last) state_d = STOP;
            STOP:      if (tick_last) state_d = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d     = (state_d != state_q || tick_last) ? '0 : tick_cnt_q + 1'b1;
        bit_cnt_d      = (state_q == DATA) ? bit_cnt_q : '0;
        shift_d        = shift_q;
        parity_bit_d   = parity_bit_q;
        data_out_d     = data_out_q;
        rx_valid_d     = FALSE;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;
        if (tick_last) begin
            case (state_q)
                DATA: begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                PARITY: parity_bit_d = rx_s;
                // Results land one clock after the mid-stop sample, even for bad frames.
                STOP: begin
                    rx_valid_d     = TRUE;
                    data_out_d     = shift_q;
                    parity_error_d = (^shift_q ^ parity_bit_q) != PARITY_ODD[0];
                    frame_error_d  = ~rx_s;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == START) || (state_q == DATA) ||
               (state_q == PARITY) || (state_q == STOP);
    end

    assign data_out     = data_out_q;
    assign rx_valid     = rx_valid_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;

endmodule
